pattern_gen: RTL

- Parametrised successor to the fixed colour-bar picker.
- Generates VGA test patterns from the raster row/col produced by the vga block, with four runtime-selectable modes: colour bars, gradient, checkerboard and solid.
- Adds per-frame bar scrolling, frame-synchronous mode latching, and a pixel clock-enable, so it runs on the system clock while tracking the slower raster.
- Sits between vga and the top-level colour mux; the output is registered with a fixed two-stage latency.

---
 rtl/pattern_gen_if.sv | 29 ++
 rtl/pattern_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pattern_gen_if.sv
// Pixel-side bus of pattern_gen: raster coordinates and controls in, colour and status out.
interface pattern_gen_if #(
    parameter int COLOR_W = 4,
    parameter int COORD_W = 10
);
    logic               pix_ce;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [1:0]         mode;
    logic               scroll_en;
    logic [COLOR_W-1:0] solid_r;
    logic [COLOR_W-1:0] solid_g;
    logic [COLOR_W-1:0] solid_b;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               in_bounds;
    logic [7:0]         frame_cnt;

    modport master (
        output pix_ce, row, col, mode, scroll_en, solid_r, solid_g, solid_b,
        input  red, green, blue, in_bounds, frame_cnt
    );

    modport slave (
        input  pix_ce, row, col, mode, scroll_en, solid_r, solid_g, solid_b,
        output red, green, blue, in_bounds, frame_cnt
    );
endinterface

// File: rtl/pattern_gen.sv
// VGA test-pattern generator: bars/gradient/checker/solid, frame-latched mode,
// per-frame bar scroll, two-stage pipeline advanced by pix_ce.
module pattern_gen #(
    parameter int COLOR_W     = 4,
    parameter int COORD_W     = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int NUM_BARS    = 8,
    parameter int CHECK_LOG2  = 5,
    parameter int SCROLL_STEP = 4
) (
    input  logic          clk_50M,
    input  logic          reset,
    pattern_gen_if.slave  bus
);
    localparam int unsigned NB    = NUM_BARS;
    localparam int unsigned BAR_W = H_ACTIVE / NUM_BARS;
    localparam logic [COORD_W:0] H_ACT_X = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0] V_ACT_X = (COORD_W+1)'(V_ACTIVE);

    typedef enum logic [1:0] {MODE_BARS, MODE_GRAD, MODE_CHECK, MODE_SOLID} mode_e;

    mode_e              mode_q, mode_d;
    logic [COLOR_W-1:0] sol_r_q, sol_g_q, sol_b_q, sol_r_d, sol_g_d, sol_b_d;
    logic [COORD_W-1:0] offset_q, offset_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               zero_seen_q, zero_seen_d;

    logic               s1_vis_q, s1_vis_d;
    logic [2:0]         s1_bar_q, s1_bar_d;
    logic               s1_chk_q, s1_chk_d;
    logic [COLOR_W-1:0] s1_gr_q, s1_gg_q;
    mode_e              s1_mode_q;

    logic [COLOR_W-1:0] red_q, green_q, blue_q, red_d, green_d, blue_d;
    logic               inb_q;

    logic               at_origin, frame_start;
    logic [COORD_W:0]   off_sum, col_sum, scol;

    function automatic logic [11:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 12'h444;
            3'd1:    palette = 12'hFF0;
            3'd2:    palette = 12'h0FF;
            3'd3:    palette = 12'h0F0;
            3'd4:    palette = 12'hF0F;
            3'd5:    palette = 12'hF00;
            3'd6:    palette = 12'h00F;
            default: palette = 12'h80F;
        endcase
    endfunction

    // Frame start updates take effect on the frame-start pixel itself, so stage 1 reads the _d values.
    always_comb begin
        at_origin   = (bus.row == '0) && (bus.col == '0);
        frame_start = bus.pix_ce && at_origin && !zero_seen_q;
        zero_seen_d = at_origin;
        off_sum     = {1'b0, offset_q} + (COORD_W+1)'(SCROLL_STEP);
        mode_d      = mode_q;
        sol_r_d     = sol_r_q;
        sol_g_d     = sol_g_q;
        sol_b_d     = sol_b_q;
        offset_d    = offset_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
            mode_d      = mode_e'(bus.mode);
            sol_r_d     = bus.solid_r;
            sol_g_d     = bus.solid_g;
            sol_b_d     = bus.solid_b;
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (bus.scroll_en)
                offset_d = (off_sum >= H_ACT_X) ? COORD_W'(off_sum - H_ACT_X) : COORD_W'(off_sum);
        end
    end

    // Bar index kept mod 8 only: the 3-bit count wraps exactly as the palette index requires.
    always_comb begin
        col_sum  = {1'b0, bus.col} + {1'b0, offset_d};
        scol     = (col_sum >= H_ACT_X) ? (col_sum - H_ACT_X) : col_sum;
        s1_bar_d = '0;
        for (int unsigned k = 1; k < NB; k++)
            if (scol >= (COORD_W+1)'(k * BAR_W))
                s1_bar_d = s1_bar_d + 3'd1;
        s1_vis_d = ({1'b0, bus.col} < H_ACT_X) && ({1'b0, bus.row} < V_ACT_X);
        s1_chk_d = bus.row[CHECK_LOG2] ^ bus.col[CHECK_LOG2];
    end

    always_comb begin
        logic [11:0] pal;
        pal     = palette(s1_bar_q);
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        case (s1_mode_q)
            MODE_BARS: begin
                red_d   = COLOR_W'(pal[11:8]) << (COLOR_W - 4);
                green_d = COLOR_W'(pal[7:4])  << (COLOR_W - 4);
                blue_d  = COLOR_W'(pal[3:0])  << (COLOR_W - 4);
            end
            MODE_GRAD: begin
                red_d   = s1_gr_q;
                green_d = s1_gg_q;
                blue_d  = COLOR_W'(frame_cnt_q);
            end
            MODE_CHECK: begin
                red_d   = {COLOR_W{s1_chk_q}};
                green_d = {COLOR_W{s1_chk_q}};
                blue_d  = {COLOR_W{s1_chk_q}};
            end
            default: begin
                red_d   = sol_r_q;
                green_d = sol_g_q;
                blue_d  = sol_b_q;
            end
        endcase
        if (!s1_vis_q) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!reset) begin
            mode_q      <= MODE_BARS;
            sol_r_q     <= '0;
            sol_g_q     <= '0;
            sol_b_q     <= '0;
            offset_q    <= '0;
            frame_cnt_q <= '0;
            zero_seen_q <= 1'b0;
            s1_vis_q    <= 1'b0;
            s1_bar_q    <= '0;
            s1_chk_q    <= 1'b0;
            s1_gr_q     <= '0;
            s1_gg_q     <= '0;
            s1_mode_q   <= MODE_BARS;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            inb_q       <= 1'b0;
        end else if (bus.pix_ce) begin
            mode_q      <= mode_d;
            sol_r_q     <= sol_r_d;
            sol_g_q     <= sol_g_d;
            sol_b_q     <= sol_b_d;
            offset_q    <= offset_d;
            frame_cnt_q <= frame_cnt_d;
            zero_seen_q <= zero_seen_d;
            s1_vis_q    <= s1_vis_d;
            s1_bar_q    <= s1_bar_d;
            s1_chk_q    <= s1_chk_d;
            s1_gr_q     <= bus.col[COORD_W-1 -: COLOR_W];
            s1_gg_q     <= bus.row[COORD_W-1 -: COLOR_W];
            s1_mode_q   <= mode_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            inb_q       <= s1_vis_q;
        end
    end

    assign bus.red       = red_q;
    assign bus.green     = green_q;
    assign bus.blue      = blue_q;
    assign bus.in_bounds = inb_q;
    assign bus.frame_cnt = frame_cnt_q;
endmodule
